// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the 8N1 UART byte blocks.
//               Holds the receiver state encoding, frame constants and the
//               default bit-rate divider (9600 baud at 50 MHz).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS      = 8;
    localparam int   DEFAULT_BPS_DR = 5207;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line plus a
//               third flop for falling-edge (start edge) detection.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               rs232_rx   - raw serial line, idle high
//               rx_sync    - synchronized line
//               start_edge - synced line is 0 while previous synced value is 1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rs232_rx,
    output logic rx_sync,
    output logic start_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All stages reset to the idle-high line level so that releasing reset
    // never fabricates a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rs232_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync    = r_sync;
    assign start_edge = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver. Detects a start edge, samples every
//               bit at mid-period, and presents the byte with a one-cycle
//               rx_done strobe, or a one-cycle frame_err strobe when the
//               stop bit reads 0.
// Ports       : clk       - system clock
//               rst       - asynchronous active-high reset
//               rs232_rx  - asynchronous serial line, idle high
//               data_byte - last correctly framed byte
//               rx_done   - one-cycle pulse when data_byte is updated
//               frame_err - one-cycle pulse when the stop bit reads 0
//               rx_busy   - high while a frame is in progress
// Options     : UART_RX_MAJORITY_EN - sample each bit as the 2-of-3 vote of
//               the line at MID_CNT-1, MID_CNT and MID_CNT+1; decision and
//               all resulting strobes move one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BPS_DR  = DEFAULT_BPS_DR,
    parameter int MID_CNT = (BPS_DR + 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] c_div_last = 16'(BPS_DR);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] c_pre_cnt    = 16'(MID_CNT - 1);
    localparam logic [15:0] c_mid_cnt    = 16'(MID_CNT);
    localparam logic [15:0] c_sample_cnt = 16'(MID_CNT + 1);
`else
    localparam logic [15:0] c_sample_cnt = 16'(MID_CNT);
`endif
    localparam logic [2:0]  c_last_bit   = 3'(DATA_BITS - 1);

    logic        w_rx;
    logic        w_start_edge;
    logic        w_sample;
    logic        w_sample_pt;
    logic        w_wrap;

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [15:0] r_div_cnt;
    logic [15:0] w_div_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_done_nxt;
    logic        w_ferr_nxt;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .rs232_rx   (rs232_rx),
        .rx_sync    (w_rx),
        .start_edge (w_start_edge)
    );

`ifdef UART_RX_MAJORITY_EN
    // The first two votes are captured one and two cycles before the
    // decision point; the third is the live synced line.
    logic r_vote0;
    logic r_vote1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if (r_div_cnt == c_pre_cnt) r_vote0 <= w_rx;
            if (r_div_cnt == c_mid_cnt) r_vote1 <= w_rx;
        end
    end

    assign w_sample = (r_vote0 & r_vote1) | (r_vote0 & w_rx) | (r_vote1 & w_rx);
`else
    assign w_sample = w_rx;
`endif

    assign w_sample_pt = (r_div_cnt == c_sample_cnt);
    assign w_wrap      = (r_div_cnt == c_div_last);
    assign rx_busy     = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_wrap ? 16'd0 : r_div_cnt + 16'd1;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = data_byte;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_div_nxt = 16'd0;
                if (w_start_edge) w_state_nxt = START;
            end
            START: begin
                if (w_sample_pt && (w_sample != START_BIT)) begin
                    // Line back high at mid-start: treat as a glitch.
                    w_state_nxt = IDLE;
                    w_div_nxt   = 16'd0;
                end else if (w_wrap) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (w_sample_pt) w_shift_nxt[r_bit_idx] = w_sample;
                if (w_wrap) begin
                    if (r_bit_idx == c_last_bit) w_state_nxt = STOP;
                    else                         w_bit_nxt   = r_bit_idx + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (w_sample_pt) begin
                    w_state_nxt = IDLE;
                    w_div_nxt   = 16'd0;
                    if (w_sample == STOP_BIT) begin
                        w_data_nxt = r_shift;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_div_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            data_byte <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            data_byte <= w_data_nxt;
            rx_done   <= w_done_nxt;
            frame_err <= w_ferr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Directed self-checking bench for uart_rx_byte with a
//               16-clock bit period (BPS_DR = 15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int BPS_DR = 15;
    localparam int BIT_CYC = BPS_DR + 1;
    localparam int MID = BIT_CYC / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LATENCY = 2 + 1 + 9 * BIT_CYC + MID + 1 + 1;
`else
    localparam int LATENCY = 2 + 1 + 9 * BIT_CYC + MID + 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;
    int start_cyc = 0;

    uart_rx_byte #(.BPS_DR(BPS_DR)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .data_byte (data_byte),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= done_cyc;
            done_cyc      <= cyc;
        end
        if (frame_err)            ferr_cnt <= ferr_cnt + 1;
        if (rx_done && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Drives one full 10-bit frame, one value per clock, changed 1 time unit
    // after each rising edge. Optional spike inverts the pin for the single
    // cycle the receiver's mid-bit sample observes.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input bit spike);
        logic v;
        for (int b = 0; b < 10; b++) begin
            v = (b == 0) ? 1'b0 : (b == 9) ? stop_val : data[b-1];
            for (int c = 0; c < BIT_CYC; c++) begin
                @(posedge clk);
                #1;
                rs232_rx = (spike && b >= 1 && b <= 8 && c == MID) ? ~v : v;
                if (b == 0 && c == 0) start_cyc = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rs232_rx = 1'b1;
        end
    endtask

    task automatic test_reset;
        rs232_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (data_byte !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_byte); end
        checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        idle(10);
    endtask

    task automatic test_frame_a5;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL a5_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL a5_ferr_count: got %0d want 0", ferr_cnt - f0); end
        checks++; if (data_byte !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", data_byte); end
        checks++; if (done_cyc - start_cyc !== LATENCY) begin errors++; $display("FAIL a5_latency: got %0d want %0d", done_cyc - start_cyc, LATENCY); end
    endtask

    task automatic test_back_to_back;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(20);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
        checks++; if (done_cyc - prev_done_cyc !== 10 * BIT_CYC) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", done_cyc - prev_done_cyc, 10 * BIT_CYC); end
        checks++; if (data_byte !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h want ff", data_byte); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr_count: got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rs232_rx = 1'b0;
        end
        idle(40);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done_count: got %0d want 0", done_cnt - d0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr_count: got %0d want 0", ferr_cnt - f0); end
        checks++; if (data_byte !== 8'hFF) begin errors++; $display("FAIL glitch_data: got %h want ff", data_byte); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_frame_err;
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        // Keep the line low (break); no further frame may start.
        for (int i = 0; i < 4 * BIT_CYC; i++) begin
            @(posedge clk);
            #1;
            rs232_rx = 1'b0;
        end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", rx_busy); end
        idle(20);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done_count: got %0d want 0", done_cnt - d0); end
        checks++; if (data_byte !== 8'hFF) begin errors++; $display("FAIL ferr_data: got %h want ff", data_byte); end
    endtask

    task automatic test_reset_mid;
        int d0, f0;
        logic [7:0] partial;
        logic v;
        int b;
        partial = 8'h6E;
        d0 = done_cnt; f0 = ferr_cnt;
        // Start bit, data bits 0..3 and half of data bit 4.
        for (int n = 0; n < 5 * BIT_CYC + MID; n++) begin
            b = n / BIT_CYC;
            v = (b == 0) ? 1'b0 : partial[b-1];
            @(posedge clk);
            #1;
            rs232_rx = v;
        end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", rx_busy); end
        rst = 1'b1;
        rs232_rx = 1'b1;
        #1;
        checks++; if (data_byte !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_byte); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", rx_busy); end
        checks++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got done=%b ferr=%b want 0 0", rx_done, frame_err); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        checks++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_no_pulse: got done=%0d ferr=%0d want 0 0", done_cnt - d0, ferr_cnt - f0); end
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        checks++; if (data_byte !== 8'h81) begin errors++; $display("FAIL after_rst_data: got %h want 81", data_byte); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL after_rst_done_count: got %0d want 1", done_cnt - d0); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority;
        int d0;
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, 1'b1);
        idle(20);
        checks++; if (data_byte !== 8'h55) begin errors++; $display("FAIL majority_data: got %h want 55", data_byte); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL majority_done_count: got %0d want 1", done_cnt - d0); end
    endtask
`endif

    task automatic test_exclusive;
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_ferr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_frame_a5;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
`ifdef UART_RX_MAJORITY_EN
        test_majority;
`endif
        test_exclusive;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
